dram_burst_responder: RTL

- Memory-side responder for the instruction-cache line-fill interface.
- Accepts a level-held request carrying a word address, waits a programmable access latency, then returns BURST_LEN consecutive 32-bit words, one per dram_val pulse.
- Backed by an internal word-addressed RAM, with a preload write port for program images and benches.
- Sits between the cache's refill port and the rest of the simulation/FPGA memory subsystem.

---
 rtl/dram_burst_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dram_burst_responder.sv
// Memory-side burst responder for the I-cache line-fill port: waits LATENCY cycles after
// accepting a request, then streams BURST_LEN words from an internal preloadable RAM.
module dram_burst_responder #(
  parameter int MEM_AW    = 14,
  parameter int BURST_LEN = 8,
  parameter int LATENCY   = 4,
  parameter int BEAT_GAP  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dram_req,
  input  logic [31:0]       dram_req_addr,
  output logic [31:0]       dram_data,
  output logic              dram_val,
  output logic              busy,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [31:0]       load_data
);

  localparam int CNT_W = 16;
  localparam int IDX_W = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {IDLE, WAIT, BEAT, GAP, DONE} state_t;

  state_t            state;
  logic [31:0]       mem [0:(1 << MEM_AW) - 1];
  logic [MEM_AW-1:0] base;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [MEM_AW-1:0] beat_addr;
  logic              unused_addr_hi;

  assign beat_addr      = base + MEM_AW'(idx);
  assign unused_addr_hi = ^dram_req_addr[31:MEM_AW];

  // Preload port is independent of the FSM and of reset; a same-cycle beat read sees old data.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dram_val  <= 1'b0;
      dram_data <= '0;
      busy      <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
    end else begin
      dram_val <= 1'b0;
      case (state)
        IDLE: begin
          if (dram_req) begin
            base <= dram_req_addr[MEM_AW-1:0];
            busy <= 1'b1;
            if (LATENCY == 0) begin
              state     <= BEAT;
              dram_val  <= 1'b1;
              dram_data <= mem[dram_req_addr[MEM_AW-1:0]];
              idx       <= IDX_W'(1);
            end else begin
              state <= WAIT;
              idx   <= '0;
              cnt   <= '0;
            end
          end
        end
        WAIT: begin
          if (!dram_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_W'(LATENCY - 1)) begin
            state     <= BEAT;
            dram_val  <= 1'b1;
            dram_data <= mem[beat_addr];
            idx       <= idx + IDX_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BEAT: begin
          if (!dram_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (idx == IDX_W'(BURST_LEN)) begin
            state <= DONE;
          end else if (BEAT_GAP > 0) begin
            state <= GAP;
            cnt   <= '0;
          end else begin
            dram_val  <= 1'b1;
            dram_data <= mem[beat_addr];
            idx       <= idx + IDX_W'(1);
          end
        end
        GAP: begin
          if (!dram_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_W'(BEAT_GAP - 1)) begin
            state     <= BEAT;
            dram_val  <= 1'b1;
            dram_data <= mem[beat_addr];
            idx       <= idx + IDX_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // The cache keeps its request up briefly after the last beat; wait for it to drop.
          if (!dram_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
